// File: rtl/hazard_pkg.sv
// hazard_pkg: result/forward codes, scoreboard entry and Tnew/match helpers
package hazard_pkg;
  localparam logic [1:0] RES_NW = 2'd0, RES_ALU = 2'd1, RES_DM = 2'd2, RES_PC = 2'd3;
  localparam logic [1:0] FWD_RF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3;
  typedef enum logic [1:0] {STG_E, STG_M, STG_W} stg_t;
  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] res;
  } sb_t;
  localparam sb_t SB_BUBBLE = '{wa: 5'd0, res: RES_NW};
  function automatic logic [1:0] tnew(input stg_t stg, input logic [1:0] res);
    return stg == STG_E ? (res == RES_ALU ? 2'd1 : res == RES_DM ? 2'd2 : 2'd0)
         : (stg == STG_M && res == RES_DM) ? 2'd1 : 2'd0;
  endfunction
  function automatic logic hit(input sb_t s, input logic [4:0] r);
    return r != 5'd0 && s.wa == r && s.res != RES_NW;
  endfunction
endpackage

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: multiply/divide busy counter
module hazard_md_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = start ? (div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) : cnt_q - CNT_W'(cnt_q != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign busy = cnt_q != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W writer scoreboard, stall generation and forwarding selects
module hazard_ctrl import hazard_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_tuse_rs0,
  input  logic       d_tuse_rs1,
  input  logic       d_tuse_rt0,
  input  logic       d_tuse_rt1,
  input  logic       d_tuse_rt2,
  input  logic [4:0] d_a1,
  input  logic [4:0] d_a2,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_res,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m
);
  sb_t e_q, m_q, w_q, e_d, m_d, w_d;
  logic [4:0] e_a1_q, e_a2_q, m_a2_q, e_a1_d, e_a2_d, m_a2_d;
  logic [1:0] tn_e, tn_m, t_rs, t_rt;
  logic stall_rs, stall_rt, md_stall;
  hazard_md_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk  (clk),
    .rst_n(rst_n),
    .start(d_md_start && !stall),
    .div  (d_md_div),
    .busy (md_busy)
  );
  always_comb begin
    tn_e = tnew(STG_E, e_q.res);
    tn_m = tnew(STG_M, m_q.res);
    t_rs = d_tuse_rs0 ? 2'd0 : 2'd1;
    t_rt = d_tuse_rt0 ? 2'd0 : d_tuse_rt1 ? 2'd1 : 2'd2;
    stall_rs = (d_tuse_rs0 || d_tuse_rs1) &&
               ((hit(e_q, d_a1) && tn_e > t_rs) || (hit(m_q, d_a1) && tn_m > t_rs));
    stall_rt = (d_tuse_rt0 || d_tuse_rt1 || d_tuse_rt2) &&
               ((hit(e_q, d_a2) && tn_e > t_rt) || (hit(m_q, d_a2) && tn_m > t_rt));
    md_stall = (d_md_start || d_md_use) && md_busy;
    stall = stall_rs || stall_rt || md_stall;
    e_d = stall ? SB_BUBBLE : sb_t'{d_wa, d_res};
    e_a1_d = stall ? 5'd0 : d_a1;
    e_a2_d = stall ? 5'd0 : d_a2;
    m_d = e_q;
    w_d = m_q;
    m_a2_d = e_a2_q;
    fwd_rs_d = (hit(e_q, d_a1) && tn_e == 2'd0) ? FWD_E : (hit(m_q, d_a1) && tn_m == 2'd0) ? FWD_M
             : hit(w_q, d_a1) ? FWD_W : FWD_RF;
    fwd_rt_d = (hit(e_q, d_a2) && tn_e == 2'd0) ? FWD_E : (hit(m_q, d_a2) && tn_m == 2'd0) ? FWD_M
             : hit(w_q, d_a2) ? FWD_W : FWD_RF;
    fwd_rs_e = (hit(m_q, e_a1_q) && tn_m == 2'd0) ? FWD_M : hit(w_q, e_a1_q) ? FWD_W : FWD_RF;
    fwd_rt_e = (hit(m_q, e_a2_q) && tn_m == 2'd0) ? FWD_M : hit(w_q, e_a2_q) ? FWD_W : FWD_RF;
    fwd_rt_m = hit(w_q, m_a2_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_q    <= SB_BUBBLE;
      m_q    <= SB_BUBBLE;
      w_q    <= SB_BUBBLE;
      e_a1_q <= '0;
      e_a2_q <= '0;
      m_a2_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      e_a1_q <= e_a1_d;
      e_a2_q <= e_a2_d;
      m_a2_q <= m_a2_d;
    end
endmodule
